// File: rtl/i2c_apb_regs.sv
// rtl/i2c_apb_regs.sv - APB3 register file for the I2C controller
//
// Purpose:
//   Register block between the APB interconnect and the I2C core/FIFOs.
//   Every transfer takes exactly one wait state. Read data and the error
//   flag are captured when the access phase is accepted. Side effects
//   (register writes, FIFO strobes, ISR clears, soft-reset loads) happen in
//   the single cycle where apb_ready is high, and only if apb_sel is still
//   asserted. Interrupts are rising-edge detected, cleared by writing 1
//   (W1C), masked by IER and gated by GIE.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   apb_sel/en/write/addr/wdata     APB3 request
//   apb_ready/rdata/slverr          APB3 response (rdata/slverr valid with ready)
//   irq                             level interrupt to the CPU
//   tx_fifo_ocy/wr/wdat             TX FIFO occupancy, push strobe, push data
//   rx_fifo_ocy/rd/rdat/pirq        RX FIFO occupancy, pop strobe, head data, threshold
//   slv_adr, cr                     slave address {ten_adr, adr} and control register
//   sr                              status from the core
//   irq_req                         level interrupt requests from the core
//   srstn                           soft reset to the core, active low

module i2c_apb_regs #(
  parameter int ADDR_W      = 9,
  parameter int FIFO_AW     = 4,
  parameter int N_IRQ       = 8,
  parameter int SRST_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 apb_sel,
  input  logic                 apb_en,
  input  logic                 apb_write,
  input  logic [31:0]          apb_addr,
  input  logic [31:0]          apb_wdata,
  output logic                 apb_ready,
  output logic [31:0]          apb_rdata,
  output logic                 apb_slverr,
  output logic                 irq,
  input  logic [FIFO_AW:0]     tx_fifo_ocy,
  output logic                 tx_fifo_wr,
  output logic [9:0]           tx_fifo_wdat,
  input  logic [FIFO_AW:0]     rx_fifo_ocy,
  output logic                 rx_fifo_rd,
  input  logic [7:0]           rx_fifo_rdat,
  output logic [FIFO_AW:0]     rx_fifo_pirq,
  output logic [9:0]           slv_adr,
  output logic [6:0]           cr,
  input  logic [7:0]           sr,
  input  logic [N_IRQ-1:0]     irq_req,
  output logic                 srstn
);

  localparam int OW = FIFO_AW + 1;
  localparam int CW = $clog2(SRST_CYCLES + 1);
  localparam logic [OW-1:0]     FIFO_FULL = OW'(1 << FIFO_AW);
  localparam logic [CW-1:0]     SRST_LOAD = CW'(SRST_CYCLES);
  localparam logic [ADDR_W-1:0] A_GIE    = ADDR_W'(12'h01C);
  localparam logic [ADDR_W-1:0] A_ISR    = ADDR_W'(12'h020);
  localparam logic [ADDR_W-1:0] A_IER    = ADDR_W'(12'h028);
  localparam logic [ADDR_W-1:0] A_SOFTR  = ADDR_W'(12'h040);
  localparam logic [ADDR_W-1:0] A_CR     = ADDR_W'(12'h100);
  localparam logic [ADDR_W-1:0] A_SR     = ADDR_W'(12'h104);
  localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'(12'h108);
  localparam logic [ADDR_W-1:0] A_RX     = ADDR_W'(12'h10C);
  localparam logic [ADDR_W-1:0] A_ADR    = ADDR_W'(12'h110);
  localparam logic [ADDR_W-1:0] A_TXOCY  = ADDR_W'(12'h114);
  localparam logic [ADDR_W-1:0] A_RXOCY  = ADDR_W'(12'h118);
  localparam logic [ADDR_W-1:0] A_TEN    = ADDR_W'(12'h11C);
  localparam logic [ADDR_W-1:0] A_PIRQ   = ADDR_W'(12'h120);

  typedef enum logic [0:0] {S_IDLE, S_ACC} state_t;

  state_t              r_state;
  logic                r_ready;
  logic [31:0]         r_rdata;
  logic                r_slverr;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_write;
  logic                r_tx_wr;
  logic [9:0]          r_tx_wdat;
  logic                r_rx_rd;
  logic                r_gie;
  logic [N_IRQ-1:0]    r_ier;
  logic [N_IRQ-1:0]    r_isr;
  logic [N_IRQ-1:0]    r_irq_d;
  logic                r_irq;
  logic [6:0]          r_cr;
  logic [6:0]          r_adr;
  logic [2:0]          r_ten;
  logic [OW-1:0]       r_pirq;
  logic [CW-1:0]       r_srst_cnt;

  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_rdata;
  logic                w_err;
  logic                w_acc_wr;
  logic [N_IRQ-1:0]    w_isr_clr;
  logic [N_IRQ-1:0]    w_isr_set;
  logic                w_unused;

  assign w_addr   = apb_addr[ADDR_W-1:0];
  assign w_unused = &{1'b0, apb_addr[31:ADDR_W]};

  // Read data and error response, decoded from the live request so they can
  // be captured on the IDLE->ACC edge.
  always_comb begin
    w_rdata = 32'h0;
    w_err   = 1'b0;
    case (w_addr)
      A_GIE:   w_rdata = {31'h0, r_gie};
      A_ISR:   w_rdata = 32'(r_isr);
      A_IER:   w_rdata = 32'(r_ier);
      A_SOFTR: w_rdata = 32'h0;
      A_CR:    w_rdata = 32'(r_cr);
      A_SR:    begin w_rdata = 32'(sr); w_err = apb_write; end
      A_TX:    w_err = apb_write && (tx_fifo_ocy == FIFO_FULL);
      A_RX: begin
        if (apb_write || rx_fifo_ocy == '0) w_err = 1'b1;
        else                                w_rdata = {24'h0, rx_fifo_rdat};
      end
      A_ADR:   w_rdata = {24'h0, r_adr, 1'b0};
      A_TXOCY: begin w_rdata = 32'(tx_fifo_ocy); w_err = apb_write; end
      A_RXOCY: begin w_rdata = 32'(rx_fifo_ocy); w_err = apb_write; end
      A_TEN:   w_rdata = 32'(r_ten);
      A_PIRQ:  w_rdata = 32'(r_pirq);
      default: begin w_rdata = 32'hDEADBEEF; w_err = 1'b1; end
    endcase
  end

  // A write only takes effect if the master still holds apb_sel in the ACC
  // cycle; dropping it aborts the transfer with no side effect.
  assign w_acc_wr  = (r_state == S_ACC) && apb_sel && r_write && !r_slverr;
  assign w_isr_clr = (w_acc_wr && r_addr == A_ISR) ? r_wdata[N_IRQ-1:0] : '0;
  assign w_isr_set = irq_req & ~r_irq_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_rdata    <= 32'h0;
      r_slverr   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_write    <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_tx_wdat  <= 10'h0;
      r_rx_rd    <= 1'b0;
      r_gie      <= 1'b0;
      r_ier      <= '0;
      r_isr      <= '0;
      r_irq_d    <= '0;
      r_irq      <= 1'b0;
      r_cr       <= 7'h0;
      r_adr      <= 7'h0;
      r_ten      <= 3'h0;
      r_pirq     <= '0;
      r_srst_cnt <= '0;
    end else begin
      r_ready <= 1'b0;
      r_tx_wr <= 1'b0;
      r_rx_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (apb_sel && apb_en && !r_ready) begin
            r_state  <= S_ACC;
            r_ready  <= 1'b1;
            r_rdata  <= w_rdata;
            r_slverr <= w_err;
            r_addr   <= w_addr;
            r_wdata  <= apb_wdata;
            r_write  <= apb_write;
            // Strobes are armed here so they are high exactly in the ACC cycle.
            r_tx_wr  <= apb_write && (w_addr == A_TX) && !w_err;
            r_rx_rd  <= !apb_write && (w_addr == A_RX) && !w_err;
            if (apb_write && (w_addr == A_TX)) r_tx_wdat <= apb_wdata[9:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_acc_wr) begin
        case (r_addr)
          A_GIE:   r_gie  <= r_wdata[0];
          A_IER:   r_ier  <= r_wdata[N_IRQ-1:0];
          A_CR:    r_cr   <= r_wdata[6:0];
          A_ADR:   r_adr  <= r_wdata[7:1];
          A_TEN:   r_ten  <= r_wdata[2:0];
          A_PIRQ:  r_pirq <= r_wdata[OW-1:0];
          default: ;
        endcase
      end

      // Set wins over a simultaneous W1C of the same bit.
      r_irq_d <= irq_req;
      r_isr   <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_irq   <= r_gie && |(r_isr & r_ier);

      // Only the exact key starts (or restarts) the soft-reset pulse.
      if (w_acc_wr && r_addr == A_SOFTR && r_wdata == 32'h0000_000A)
        r_srst_cnt <= SRST_LOAD;
      else if (r_srst_cnt != '0)
        r_srst_cnt <= r_srst_cnt - CW'(1);
    end
  end

  assign apb_ready    = r_ready;
  assign apb_rdata    = r_rdata;
  assign apb_slverr   = r_slverr;
  assign irq          = r_irq;
  assign tx_fifo_wr   = r_tx_wr && apb_sel;
  assign tx_fifo_wdat = r_tx_wdat;
  assign rx_fifo_rd   = r_rx_rd && apb_sel;
  assign rx_fifo_pirq = r_pirq;
  assign slv_adr      = {r_ten, r_adr};
  assign cr           = r_cr;
  assign srstn        = (r_srst_cnt == '0);

endmodule

// File: tb/tb_i2c_apb_regs.sv
// tb/tb_i2c_apb_regs.sv - self-checking bench for i2c_apb_regs

module tb_i2c_apb_regs;

  logic        clk = 1'b0;
  logic        rstn;
  logic        apb_sel, apb_en, apb_write;
  logic [31:0] apb_addr, apb_wdata;
  logic        apb_ready;
  logic [31:0] apb_rdata;
  logic        apb_slverr;
  logic        irq;
  logic [4:0]  tx_fifo_ocy;
  logic        tx_fifo_wr;
  logic [9:0]  tx_fifo_wdat;
  logic [4:0]  rx_fifo_ocy;
  logic        rx_fifo_rd;
  logic [7:0]  rx_fifo_rdat;
  logic [4:0]  rx_fifo_pirq;
  logic [9:0]  slv_adr;
  logic [6:0]  cr;
  logic [7:0]  sr;
  logic [7:0]  irq_req;
  logic        srstn;

  always #5 clk = ~clk;

  i2c_apb_regs dut (
    .clk(clk), .rstn(rstn),
    .apb_sel(apb_sel), .apb_en(apb_en), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata), .apb_slverr(apb_slverr),
    .irq(irq),
    .tx_fifo_ocy(tx_fifo_ocy), .tx_fifo_wr(tx_fifo_wr), .tx_fifo_wdat(tx_fifo_wdat),
    .rx_fifo_ocy(rx_fifo_ocy), .rx_fifo_rd(rx_fifo_rd), .rx_fifo_rdat(rx_fifo_rdat),
    .rx_fifo_pirq(rx_fifo_pirq),
    .slv_adr(slv_adr), .cr(cr), .sr(sr), .irq_req(irq_req), .srstn(srstn)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tx_cnt = 0, rx_cnt = 0, srst_low = 0;
  logic [9:0] tx_last = 10'h0;

  // Strobe / soft-reset observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_fifo_wr) begin tx_cnt++; tx_last = tx_fifo_wdat; end
    if (rx_fifo_rd) rx_cnt++;
    if (!srstn) srst_low++;
  end

  // Reference state for the register file.
  logic       m_gie;
  logic [7:0] m_ier, m_isr, m_adr;
  logic [6:0] m_cr;
  logic [2:0] m_ten;
  logic [4:0] m_pirq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic ack_irq_en, input logic [7:0] ack_irq,
                          output logic [31:0] rd, output logic err);
    int waits;
    bit got;
    @(negedge clk);
    apb_sel = 1'b1; apb_en = 1'b0; apb_write = wr; apb_addr = addr; apb_wdata = wd;
    @(negedge clk);
    apb_en = 1'b1;
    waits = 0;
    got   = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      waits++;
      if (apb_ready) got = 1'b1;
    end
    if (ack_irq_en) irq_req = ack_irq;
    rd  = apb_rdata;
    err = apb_slverr;
    check("wait_states", got ? waits : 99, 1);
    @(negedge clk);
    check("ready_one_cycle", apb_ready, 1'b0);
    apb_sel = 1'b0; apb_en = 1'b0; apb_write = 1'b0;
  endtask

  task automatic model_xfer(input logic wr, input logic [8:0] a, input logic [31:0] wd);
    logic [31:0] erd, rd;
    logic        eerr, err;
    int          etx, erx, tx0, rx0;
    erd = 32'h0; eerr = 1'b0; etx = 0; erx = 0;
    case (a)
      9'h01C: if (wr) m_gie = wd[0];       else erd = {31'h0, m_gie};
      9'h020: if (wr) m_isr = m_isr & ~wd[7:0]; else erd = 32'(m_isr);
      9'h028: if (wr) m_ier = wd[7:0];     else erd = 32'(m_ier);
      9'h040: ;
      9'h100: if (wr) m_cr = wd[6:0];      else erd = 32'(m_cr);
      9'h104: if (wr) eerr = 1'b1;         else erd = 32'(sr);
      9'h108: if (wr) begin
                if (tx_fifo_ocy == 5'd16) eerr = 1'b1; else etx = 1;
              end
      9'h10C: if (wr || rx_fifo_ocy == 0) eerr = 1'b1;
              else begin erd = 32'(rx_fifo_rdat); erx = 1; end
      9'h110: if (wr) m_adr = wd[7:0] & 8'hFE; else erd = 32'(m_adr);
      9'h114: if (wr) eerr = 1'b1;         else erd = 32'(tx_fifo_ocy);
      9'h118: if (wr) eerr = 1'b1;         else erd = 32'(rx_fifo_ocy);
      9'h11C: if (wr) m_ten = wd[2:0];     else erd = 32'(m_ten);
      9'h120: if (wr) m_pirq = wd[4:0];    else erd = 32'(m_pirq);
      default: begin erd = 32'hDEADBEEF; eerr = 1'b1; end
    endcase
    tx0 = tx_cnt; rx0 = rx_cnt;
    apb_xfer(wr, ($urandom() & ~32'h1FF) | 32'(a), wd, 1'b0, 8'h0, rd, err);
    check($sformatf("slverr_%s_%h", wr ? "wr" : "rd", a), err, eerr);
    if (!wr) check($sformatf("rdata_%h", a), rd, erd);
    check($sformatf("tx_pushes_%h", a), tx_cnt - tx0, etx);
    if (etx != 0) check("tx_wdat", tx_last, wd[9:0]);
    check($sformatf("rx_pops_%h", a), rx_cnt - rx0, erx);
    @(negedge clk);
    check("cr", cr, m_cr);
    check("slv_adr", slv_adr, {m_ten, m_adr[7:1]});
    check("rx_fifo_pirq", rx_fifo_pirq, m_pirq);
    check("irq", irq, m_gie & |(m_isr & m_ier));
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          t0, r0, s0;
    logic [8:0]  amap [18];
    amap = '{9'h01C, 9'h020, 9'h028, 9'h040, 9'h100, 9'h104, 9'h108, 9'h10C, 9'h110,
             9'h114, 9'h118, 9'h11C, 9'h120, 9'h000, 9'h0F0, 9'h124, 9'h1FC, 9'h030};

    rstn = 1'b0; apb_sel = 1'b0; apb_en = 1'b0; apb_write = 1'b0;
    apb_addr = 32'h0; apb_wdata = 32'h0; tx_fifo_ocy = 5'd0; rx_fifo_ocy = 5'd0;
    rx_fifo_rdat = 8'h0; sr = 8'h0; irq_req = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", apb_ready, 1'b0);
    check("rst_rdata", apb_rdata, 32'h0);
    check("rst_slverr", apb_slverr, 1'b0);
    check("rst_srstn", srstn, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_cr", cr, 7'h0);
    check("rst_slv_adr", slv_adr, 10'h0);
    check("rst_pirq", rx_fifo_pirq, 5'h0);
    check("rst_tx_wr", tx_fifo_wr, 1'b0);
    check("rst_rx_rd", rx_fifo_rd, 1'b0);
    rstn = 1'b1;

    // Control register round trip.
    apb_xfer(1'b1, 32'h100, 32'h55, 1'b0, 8'h0, rd, err);
    check("cr_wr_err", err, 1'b0);
    apb_xfer(1'b0, 32'h100, 32'h0, 1'b0, 8'h0, rd, err);
    check("cr_rd_data", rd, 32'h55);
    check("cr_rd_err", err, 1'b0);

    // TX FIFO full protection, then a normal push.
    tx_fifo_ocy = 5'd16; t0 = tx_cnt;
    apb_xfer(1'b1, 32'h108, 32'h1A5, 1'b0, 8'h0, rd, err);
    check("tx_full_err", err, 1'b1);
    check("tx_full_pushes", tx_cnt - t0, 0);
    tx_fifo_ocy = 5'd3; t0 = tx_cnt;
    apb_xfer(1'b1, 32'h108, 32'h1A5, 1'b0, 8'h0, rd, err);
    check("tx_ok_err", err, 1'b0);
    check("tx_ok_pushes", tx_cnt - t0, 1);
    check("tx_ok_wdat", tx_last, 10'h1A5);

    // RX FIFO empty protection, then a normal pop.
    rx_fifo_ocy = 5'd0; r0 = rx_cnt;
    apb_xfer(1'b0, 32'h10C, 32'h0, 1'b0, 8'h0, rd, err);
    check("rx_empty_data", rd, 32'h0);
    check("rx_empty_err", err, 1'b1);
    check("rx_empty_pops", rx_cnt - r0, 0);
    rx_fifo_ocy = 5'd2; rx_fifo_rdat = 8'h3C; r0 = rx_cnt;
    apb_xfer(1'b0, 32'h10C, 32'h0, 1'b0, 8'h0, rd, err);
    check("rx_ok_data", rd, 32'h3C);
    check("rx_ok_err", err, 1'b0);
    check("rx_ok_pops", rx_cnt - r0, 1);

    // Edge-detected interrupts with W1C.
    apb_xfer(1'b1, 32'h01C, 32'h1, 1'b0, 8'h0, rd, err);
    apb_xfer(1'b1, 32'h028, 32'h04, 1'b0, 8'h0, rd, err);
    irq_req = 8'h04;
    repeat (20) @(negedge clk);
    apb_xfer(1'b0, 32'h020, 32'h0, 1'b0, 8'h0, rd, err);
    check("isr_set", rd, 32'h04);
    check("irq_set", irq, 1'b1);
    apb_xfer(1'b1, 32'h020, 32'h04, 1'b0, 8'h0, rd, err);
    apb_xfer(1'b0, 32'h020, 32'h0, 1'b0, 8'h0, rd, err);
    check("isr_clr_held", rd, 32'h0);
    check("irq_clr", irq, 1'b0);
    irq_req = 8'h00;
    repeat (2) @(negedge clk);
    apb_xfer(1'b1, 32'h020, 32'h04, 1'b1, 8'h04, rd, err);
    apb_xfer(1'b0, 32'h020, 32'h0, 1'b0, 8'h0, rd, err);
    check("isr_set_beats_clr", rd, 32'h04);
    check("irq_set_beats_clr", irq, 1'b1);

    // Soft reset pulse: plain, extended, and wrong key.
    s0 = srst_low;
    apb_xfer(1'b1, 32'h040, 32'hA, 1'b0, 8'h0, rd, err);
    check("softr_err", err, 1'b0);
    repeat (25) @(negedge clk);
    check("softr_low_cycles", srst_low - s0, 10);
    s0 = srst_low;
    apb_xfer(1'b1, 32'h040, 32'hA, 1'b0, 8'h0, rd, err);
    @(negedge clk);
    apb_xfer(1'b1, 32'h040, 32'hA, 1'b0, 8'h0, rd, err);
    repeat (30) @(negedge clk);
    check("softr_extended_cycles", srst_low - s0, 15);
    s0 = srst_low;
    apb_xfer(1'b1, 32'h040, 32'hB, 1'b0, 8'h0, rd, err);
    check("softr_bad_key_err", err, 1'b0);
    repeat (20) @(negedge clk);
    check("softr_bad_key_cycles", srst_low - s0, 0);

    // Unmapped read.
    apb_xfer(1'b0, 32'h0F0, 32'h0, 1'b0, 8'h0, rd, err);
    check("unmapped_data", rd, 32'hDEADBEEF);
    check("unmapped_err", err, 1'b1);

    // Master drops apb_sel in the ACC cycle: CR write must not land.
    @(negedge clk);
    apb_sel = 1'b1; apb_en = 1'b0; apb_write = 1'b1; apb_addr = 32'h100; apb_wdata = 32'h11;
    @(negedge clk);
    apb_en = 1'b1;
    @(negedge clk);
    check("abort_in_acc", apb_ready, 1'b1);
    apb_sel = 1'b0; apb_en = 1'b0; apb_write = 1'b0;
    @(negedge clk);
    check("abort_cr_kept", cr, 7'h55);

    // Randomized traffic against the reference model.
    m_gie = 1'b1; m_ier = 8'h04; m_isr = 8'h04; m_cr = 7'h55;
    m_adr = 8'h0; m_ten = 3'h0; m_pirq = 5'h0;
    for (int n = 0; n < 150; n++) begin
      logic [8:0]  a;
      logic [31:0] wd;
      logic        wr;
      a  = amap[$urandom_range(0, 17)];
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      if (a == 9'h040) wd = wd | 32'h100;
      tx_fifo_ocy  = ($urandom_range(0, 3) == 0) ? 5'd16 : 5'($urandom_range(0, 15));
      rx_fifo_ocy  = ($urandom_range(0, 3) == 0) ? 5'd0  : 5'($urandom_range(1, 16));
      rx_fifo_rdat = 8'($urandom());
      sr           = 8'($urandom());
      model_xfer(wr, a, wd);
    end

    // Asynchronous reset in the middle of an RX read.
    apb_xfer(1'b1, 32'h028, 32'hFF, 1'b0, 8'h0, rd, err);
    apb_xfer(1'b1, 32'h01C, 32'h1, 1'b0, 8'h0, rd, err);
    apb_xfer(1'b1, 32'h100, 32'h33, 1'b0, 8'h0, rd, err);
    irq_req = 8'h00;
    repeat (2) @(negedge clk);
    irq_req = 8'h01;
    repeat (3) @(negedge clk);
    check("pre_rst_irq", irq, 1'b1);
    apb_xfer(1'b1, 32'h040, 32'hA, 1'b0, 8'h0, rd, err);
    rx_fifo_ocy = 5'd2; rx_fifo_rdat = 8'h3C;
    @(negedge clk);
    apb_sel = 1'b1; apb_en = 1'b0; apb_write = 1'b0; apb_addr = 32'h10C;
    @(negedge clk);
    apb_en = 1'b1;
    @(negedge clk);
    check("pre_rst_rx_rd", rx_fifo_rd, 1'b1);
    check("pre_rst_srstn", srstn, 1'b0);
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", apb_ready, 1'b0);
    check("mid_rst_rdata", apb_rdata, 32'h0);
    check("mid_rst_slverr", apb_slverr, 1'b0);
    check("mid_rst_rx_rd", rx_fifo_rd, 1'b0);
    check("mid_rst_tx_wr", tx_fifo_wr, 1'b0);
    check("mid_rst_srstn", srstn, 1'b1);
    check("mid_rst_irq", irq, 1'b0);
    check("mid_rst_cr", cr, 7'h0);
    apb_sel = 1'b0; apb_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    apb_xfer(1'b0, 32'h100, 32'h0, 1'b0, 8'h0, rd, err);
    check("post_rst_cr", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
